hex_display_driver: RTL and testbench
=====================================

// Module: hex_display_driver
// PURPOSE
//  Display-side consumer of an ALU result on the board's multiplexed 7-segment bank. Accepts a
//  32-bit word plus ZNV flags over valid/ready and holds it in a shadow register. It commits the
//  word only at a frame boundary, so the display never tears. It then scans NDIGITS digits with
//  a refresh counter, driving active-low segment and anode lines and flag LEDs.
// PARAMETERS
//  NDIGITS      8      digits scanned; digit i shows value[4i+3:4i]; 1..8
//  REFRESH_DIV  50000  CLK cycles each digit is lit; >=2
// PORTS
//  CLK          in   1        system clock, all state on rising edge
//  RST          in   1        synchronous, active-high reset
//  in_valid     in   1        value/flags presented
//  in_ready     out  1        driver can accept; transfer when in_valid && in_ready
//  in_value     in   32       word to display
//  in_flags     in   3        {overflow, negative, zero}
//  blank_lz     in   1        1 = blank leading-zero digits
//  seg_n        out  7        segments {g,f,e,d,c,b,a}, active low
//  an_n         out  NDIGITS  digit enables, active low, one-hot-low
//  led_flags    out  3        committed {overflow, negative, zero}, active high
//  frame_tick   out  1        1-cycle pulse at each frame boundary
// BEHAVIOUR
//  Reset: seg_n='1, an_n='1, led_flags=0, frame_tick=0, in_ready=1. refresh_cnt=0, digit_idx=0,
//   shadow, disp_reg and pending all 0. RST dominates every other input.
//  Refresh counter: refresh_cnt counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and
//   digit_idx advances mod NDIGITS.
//  Frame boundary (FB): refresh_cnt==REFRESH_DIV-1 && digit_idx==NDIGITS-1. frame_tick is
//   registered and goes high in the cycle after FB.
//  Handshake: in_ready = ~pending, combinational from a register.
//   On accept: shadow <= {in_value, in_flags} and pending <= 1.
//   On FB with pending=1: disp_reg <= shadow and pending <= 0, so in_ready rises next cycle.
//   Accept and FB in the same cycle with pending=0: the word is stored and committed at the
//   following FB, never the current one.
//   in_valid while pending=1 is held off; the source must keep in_value stable.
//  Latency: an accepted word reaches seg_n/led_flags between 2 and NDIGITS*REFRESH_DIV+1 cycles
//   after accept.
//  Outputs are registered every cycle from the current digit_idx and disp_reg.
//   an_n = ~(1<<digit_idx); seg_n = hex_to_7seg(nibble[digit_idx]); led_flags = disp_reg flags.
//   The first valid scan output appears 1 cycle after reset release.
//  Leading-zero blanking (blank_lz=1): digit i blanks (seg_n='1, anode still driven) if all
//   nibbles >= i are 0 and i != 0. Value 0 therefore shows a single '0' on digit 0.
//   blank_lz is sampled every cycle and is not latched.
//  Encoding (seg_n hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21
//   E:06 F:0E.
//  Mid-operation reset: the pending word is discarded; the display blanks, then rescans 0.
// STRUCTURE
//  display_types_pkg: seg_t (logic[6:0]), SEG_BLANK='1, the 16-entry SEG_LUT constant array,
//   and flags_t struct {overflow, negative, zero}.
//  Sub-module hex_to_7seg: combinational, nibble in, seg_t out via SEG_LUT, instantiated once
//   on the selected nibble.
//  Top holds refresh_cnt ($clog2(REFRESH_DIV) bits), digit_idx, shadow/pending, disp_reg and
//   the output registers.
// TESTING  (NDIGITS=8, REFRESH_DIV=4)
//  1 Reset held 3 cycles -> seg_n=7F, an_n=FF, led_flags=0, in_ready=1. After release, an_n=FE
//    and seg_n=40 for 4 cycles, then an_n=FD.
//  2 Accept 0x1234ABCD, flags=3'b010 -> in_ready=0 until after next FB. Over the following frame:
//    digit0 seg_n=21(d), digit1 46, digit2 03, digit3 08, digit4 19, digit5 30, digit6 24,
//    digit7 79; led_flags=010.
//  3 Backpressure: 0x11111111 accepted, then 0x22222222 held valid -> not taken while pending.
//    Taken 1 cycle after in_ready rises. Next frame shows all '1' (79); the frame after shows
//    all '2' (24).
//  4 Accept exactly on the FB cycle -> the current frame still shows the old word, frame_tick
//    pulses, and the new word appears one frame later.
//  5 blank_lz=1 with 0x000000A0 -> digits 2..7 seg_n=7F, digit1=08, digit0=40.
//    With 0x00000000 -> only digit0 lit, showing 40.
//  6 RST asserted mid-frame with pending=1 -> next cycle all outputs at reset values and
//    in_ready=1. The word is lost; the display rescans 0 from digit0.

Source files
------------

// File: rtl/hex_display_driver_pkg.sv
// Shared display types: segment codes, the hex glyph table and flag/word layouts.
package display_types_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = '1;

    // Active-low {g,f,e,d,c,b,a} glyphs for 0..F
    localparam seg_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic overflow;
        logic negative;
        logic zero;
    } flags_t;

    typedef struct packed {
        logic [31:0] value;
        flags_t      flags;
    } disp_word_t;

endpackage

// File: rtl/hex_display_driver_if.sv
// Valid/ready input bus carrying an ALU result word and its ZNV flags.
interface hex_display_driver_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [2:0]  in_flags;

    modport master (output in_valid, output in_value, output in_flags, input in_ready);
    modport slave  (input in_valid, input in_value, input in_flags, output in_ready);

endinterface

// File: rtl/hex_display_driver_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment glyph.
module hex_to_7seg
    import display_types_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/hex_display_driver.sv
// Multiplexed 7-segment driver: shadows an incoming word, commits it only at a
// frame boundary so the display never tears, and scans NDIGITS digits.
module hex_display_driver
    import display_types_pkg::*;
#(
    parameter int unsigned NDIGITS     = 8,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                 CLK,
    input  logic                 RST,
    hex_display_driver_if.slave  in_bus,
    input  logic                 blank_lz,
    output logic [6:0]           seg_n,
    output logic [NDIGITS-1:0]   an_n,
    output logic [2:0]           led_flags,
    output logic                 frame_tick
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [CW-1:0]      refresh_cnt_q, refresh_cnt_d;
    logic [DW-1:0]      digit_idx_q,   digit_idx_d;
    disp_word_t         shadow_q,      shadow_d;
    disp_word_t         disp_q,        disp_d;
    logic               pending_q,     pending_d;
    seg_t               seg_q,         seg_d;
    logic [NDIGITS-1:0] an_q,          an_d;
    flags_t             led_q;
    logic               tick_q;

    logic               refresh_wrap;
    logic               frame_bound;
    logic               accept;
    logic [31:0]        upper_nibbles;
    seg_t               glyph;

    assign refresh_wrap = (refresh_cnt_q == CW'(REFRESH_DIV - 1));
    assign frame_bound  = refresh_wrap && (digit_idx_q == DW'(NDIGITS - 1));
    assign accept       = in_bus.in_valid && !pending_q;
    assign in_bus.in_ready = ~pending_q;

    // Nibbles at and above the current digit; its low nibble is the digit shown
    assign upper_nibbles = disp_q.value >> (4 * digit_idx_q);

    hex_to_7seg u_hex_to_7seg (
        .nibble_i (upper_nibbles[3:0]),
        .seg_o    (glyph)
    );

    // Refresh counter and digit scan position
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + CW'(1);
        digit_idx_d   = digit_idx_q;
        if (refresh_wrap) begin
            refresh_cnt_d = '0;
            digit_idx_d   = (digit_idx_q == DW'(NDIGITS - 1)) ? '0 : digit_idx_q + DW'(1);
        end
    end

    // Shadow capture and frame-boundary commit; accept needs pending=0 and
    // commit needs pending=1, so a same-cycle accept waits for the next boundary
    always_comb begin
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (accept) begin
            shadow_d  = '{value: in_bus.in_value, flags: flags_t'(in_bus.in_flags)};
            pending_d = 1'b1;
        end else if (frame_bound && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Scan outputs for the current digit, with optional leading-zero blanking
    always_comb begin
        an_d  = ~(NDIGITS'(1) << digit_idx_q);
        seg_d = glyph;
        if (blank_lz && (digit_idx_q != '0) && (upper_nibbles == '0)) begin
            seg_d = SEG_BLANK;
        end
    end

    // State and output registers, synchronous reset dominant
    always_ff @(posedge CLK) begin
        if (RST) begin
            refresh_cnt_q <= '0;
            digit_idx_q   <= '0;
            shadow_q      <= '0;
            disp_q        <= '0;
            pending_q     <= 1'b0;
            seg_q         <= SEG_BLANK;
            an_q          <= '1;
            led_q         <= '0;
            tick_q        <= 1'b0;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            led_q         <= disp_q.flags;
            tick_q        <= frame_bound;
        end
    end

    assign seg_n      = seg_q;
    assign an_n       = an_q;
    assign led_flags  = led_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Scoreboard bench: the driver pushes each accepted word with its commit time;
// the monitor retires commits and checks every scan output cycle.
module tb_hex_display_driver;

    localparam int unsigned ND    = 8;
    localparam int unsigned RD    = 4;
    localparam int unsigned FRAME = ND * RD;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic [2:0]  led_flags;
    logic        frame_tick;

    hex_display_driver_if bus ();

    hex_display_driver #(.NDIGITS(ND), .REFRESH_DIV(RD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_bus     (bus),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .led_flags  (led_flags),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    // Edges since reset release; after edge e this reads e
    int cyc = 0;
    always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

    typedef struct {
        logic [31:0] value;
        logic [2:0]  flags;
        int          a;     // accept edge
        int          f;     // commit edge (first frame boundary strictly after a)
    } commit_t;

    commit_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_value = '0;
    logic [2:0]  m_flags = '0;

    function automatic logic [6:0] glyph_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: reference view of the display after every edge
    int          e, d;
    logic [31:0] hi;
    logic [6:0]  exp_seg;
    logic [7:0]  exp_an;
    bit          pend;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
                sb.delete();
                m_value = '0;
                m_flags = '0;
                chk("reset_seg_n", 32'(seg_n), 32'h7F);
                chk("reset_an_n", 32'(an_n), 32'hFF);
                chk("reset_led_flags", 32'(led_flags), 32'h0);
                chk("reset_frame_tick", 32'(frame_tick), 32'h0);
                chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
            end else begin
                e = cyc;
                while (sb.size() > 0 && sb[0].f < e) begin
                    m_value = sb[0].value;
                    m_flags = sb[0].flags;
                    void'(sb.pop_front());
                end
                pend    = (sb.size() > 0) && (sb[0].a <= e) && (sb[0].f > e);
                d       = ((e - 1) / RD) % ND;
                hi      = m_value >> (4 * d);
                exp_seg = (blank_lz && d != 0 && hi == 0) ? 7'h7F : glyph_ref(hi[3:0]);
                exp_an  = ~(8'(1) << d);
                chk("seg_n", 32'(seg_n), 32'(exp_seg));
                chk("an_n", 32'(an_n), 32'(exp_an));
                chk("led_flags", 32'(led_flags), 32'(m_flags));
                chk("frame_tick", 32'(frame_tick), 32'((e % FRAME) == 0));
                chk("in_ready", 32'(bus.in_ready), 32'(!pend));
            end
        end
    end

    // Present a word from a negedge and hold it until accepted
    task automatic send(input logic [31:0] v, input logic [2:0] fl);
        bit done = 0;
        int a;
        bus.in_valid = 1'b1;
        bus.in_value = v;
        bus.in_flags = fl;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.in_ready) begin
                a = cyc + 1;
                sb.push_back('{value: v, flags: fl, a: a, f: ((a / FRAME) + 1) * FRAME});
                done = 1;
            end
            @(negedge CLK);
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready expected accept of %0h", v);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Wait until the next edge has the requested position within the frame
    task automatic align(input int phase);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (((cyc + 1) % FRAME) == phase && bus.in_ready) break;
            @(negedge CLK);
        end
    endtask

    task automatic finish_report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [31:0] v;
        bus.in_valid = 1'b0;
        bus.in_value = '0;
        bus.in_flags = '0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        idle(40);

        send(32'h1234ABCD, 3'b010);
        idle(70);

        send(32'h11111111, 3'b000);
        send(32'h22222222, 3'b100);
        idle(70);

        align(0);
        send(32'hCAFEF00D, 3'b101);
        idle(70);

        blank_lz = 1'b1;
        send(32'h000000A0, 3'b000);
        idle(70);
        send(32'h00000000, 3'b001);
        idle(70);

        for (int k = 0; k < 12; k++) begin
            v = $urandom;
            v = v >> $urandom_range(0, 31);
            send(v, 3'($urandom_range(0, 7)));
            for (int j = 0; j < int'($urandom_range(0, 45)); j++) begin
                blank_lz = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
        end
        idle(70);

        blank_lz = 1'b0;
        align(2);
        send(32'h89ABCDEF, 3'b111);
        idle(5);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        idle(80);

        finish_report();
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no completion expected end of stimulus");
        finish_report();
    end

endmodule
